por_reset_sequencer: RTL and testbench



---
 rtl/por_seq_pkg.sv | 29 ++
 rtl/por_reset_sequencer_if.sv | 37 +++
 rtl/por_reset_sequencer.sv | 145 ++++++++++++++
 tb/tb_por_reset_sequencer.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/por_seq_pkg.sv
// Shared types for the power-on reset sequencer: FSM states, reset causes
// and a small helper used to size the shared phase counter.
package por_seq_pkg;

  localparam int unsigned CAUSE_W = 2;

  typedef enum logic [1:0] {
    HOLD      = 2'b00,
    WAIT_LOCK = 2'b01,
    RELEASE   = 2'b10,
    RUN       = 2'b11
  } por_seq_state_e;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_POR = 2'b01,
    CAUSE_SW  = 2'b10,
    CAUSE_WDT = 2'b11
  } rst_cause_e;

  // Largest of the three phase lengths; one counter serves every phase.
  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/por_reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the rest of the SoC:
// PLL lock and reset requests in, per-domain resets and status out.
interface por_reset_sequencer_if #(
  parameter int unsigned N_DOMAINS = 4
) ();

  logic                 pll_lock_i;
  logic                 sw_rst_req_i;
  logic                 wdt_rst_req_i;
  logic [N_DOMAINS-1:0] dom_rst_n_o;
  logic                 ready_o;
  logic [1:0]           rst_cause_o;
  logic                 lock_timeout_o;

  // System side: supplies lock and requests, consumes the resets.
  modport master (
    output pll_lock_i,
    output sw_rst_req_i,
    output wdt_rst_req_i,
    input  dom_rst_n_o,
    input  ready_o,
    input  rst_cause_o,
    input  lock_timeout_o
  );

  // Sequencer side.
  modport slave (
    input  pll_lock_i,
    input  sw_rst_req_i,
    input  wdt_rst_req_i,
    output dom_rst_n_o,
    output ready_o,
    output rst_cause_o,
    output lock_timeout_o
  );

endinterface

// File: rtl/por_reset_sequencer.sv
// Holds all core reset domains after POR, waits for PLL lock (or timeout),
// then releases the domains one by one; SW/WDT requests restart the sequence.
module por_reset_sequencer
  import por_seq_pkg::*;
#(
  parameter int unsigned N_DOMAINS      = 4,
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned STAGGER_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  por_reset_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(max3(HOLD_CYCLES, STAGGER_CYCLES, LOCK_TIMEOUT)) + 1;
  localparam int unsigned IDX_W = $clog2(N_DOMAINS + 1);

  por_seq_state_e       state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_DOMAINS-1:0] dom_q, dom_d;
  logic                 ready_q, ready_d;
  rst_cause_e           cause_q, cause_d;
  logic                 lt_q, lt_d;

  logic hold_done_c;
  logic lock_to_c;
  logic stagger_done_c;
  logic last_dom_c;
  logic req_c;

  assign hold_done_c    = (cnt_q == CNT_W'(HOLD_CYCLES - 1));
  assign lock_to_c      = (cnt_q == CNT_W'(LOCK_TIMEOUT - 1));
  assign stagger_done_c = (cnt_q == CNT_W'(STAGGER_CYCLES - 1));
  assign last_dom_c     = (idx_q == IDX_W'(N_DOMAINS - 1));
  assign req_c          = bus.sw_rst_req_i | bus.wdt_rst_req_i;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; every output comes straight from one of these.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      dom_q   <= '0;
      ready_q <= 1'b0;
      cause_q <= CAUSE_POR;
      lt_q    <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dom_q   <= dom_d;
      ready_q <= ready_d;
      cause_q <= cause_d;
      lt_q    <= lt_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dom_d   = dom_q;
    ready_d = ready_q;
    cause_d = cause_q;
    lt_d    = lt_q;

    unique case (state_q)
      HOLD: begin
        if (hold_done_c) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      WAIT_LOCK: begin
        if (bus.pll_lock_i || lock_to_c) begin
          dom_d = N_DOMAINS'(1);
          idx_d = IDX_W'(1);
          cnt_d = '0;
          // Flag only a release that lock itself did not justify.
          if (!bus.pll_lock_i) lt_d = 1'b1;
          if (N_DOMAINS == 1) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RELEASE: begin
        if (stagger_done_c) begin
          dom_d = dom_q | (N_DOMAINS'(1) << idx_q);
          idx_d = idx_q + IDX_W'(1);
          cnt_d = '0;
          if (last_dom_c) begin
            state_d = RUN;
            ready_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RUN: begin
        // Terminal until a request or rst_n; lock loss is deliberately ignored.
      end

      default: begin
        state_d = HOLD;
        cnt_d   = '0;
      end
    endcase

    // Requests override whatever phase is in progress and re-assert every domain.
    if (req_c) begin
      state_d = HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      dom_d   = '0;
      ready_d = 1'b0;
      cause_d = bus.wdt_rst_req_i ? CAUSE_WDT : CAUSE_SW;
    end
  end

  assign bus.dom_rst_n_o    = dom_q;
  assign bus.ready_o        = ready_q;
  assign bus.rst_cause_o    = cause_q;
  assign bus.lock_timeout_o = lt_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Event scoreboard for the reset sequencer: expected output changes (edge and
// value) are queued as stimulus is applied and matched as the DUTs change.
module tb_por_reset_sequencer;
  import por_seq_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n = 1'b1;
  logic rst1_n = 1'b1;

  por_reset_sequencer_if #(.N_DOMAINS(4)) bus0 ();
  por_reset_sequencer_if #(.N_DOMAINS(4)) bus1 ();

  por_reset_sequencer #(
    .N_DOMAINS(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(8), .LOCK_TIMEOUT(1024)
  ) u_dut0 (
    .clk(clk), .rst_n(rst0_n), .bus(bus0.slave)
  );

  por_reset_sequencer #(
    .N_DOMAINS(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(8), .LOCK_TIMEOUT(64)
  ) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .bus(bus1.slave)
  );

  int n_vec = 0;
  int n_err = 0;
  int e0 = 0;
  int e1 = 0;

  // Edge numbers: edge 1 is the first rising edge with rst_n high.
  always @(posedge clk or negedge rst0_n) if (!rst0_n) e0 <= 0; else e0 <= e0 + 1;
  always @(posedge clk or negedge rst1_n) if (!rst1_n) e1 <= 0; else e1 <= e1 + 1;

  typedef struct {
    int         id;
    int         edge_n;
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] prev [2] = '{8'h02, 8'h02};

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pk(logic [3:0] d, logic r, logic [1:0] c, logic l);
    return {d, r, c, l};
  endfunction

  function automatic int cnt_of(int id);
    return (id == 0) ? e0 : e1;
  endfunction

  task automatic push(int id, int e, logic [7:0] v);
    ev_t ev;
    ev.id = id;
    ev.edge_n = e;
    ev.val = v;
    exp_q.push_back(ev);
  endtask

  // Release events of a sequence whose edge 0 is 'base'; rel = edge of domain 0.
  task automatic push_seq(int id, int base, int rel, int ndom, logic [1:0] c, logic lt);
    for (int k = 0; k < ndom; k++)
      push(id, base + rel + k * 8, pk(4'((1 << (k + 1)) - 1), (k == 3), c, lt));
  endtask

  task automatic observe(int id, int e, logic [7:0] cur);
    ev_t ev;
    if (cur === prev[id]) return;
    prev[id] = cur;
    chk($sformatf("evt_pending_dut%0d", id), 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() == 0) return;
    ev = exp_q.pop_front();
    chk($sformatf("evt_id_dut%0d", id), 32'(id), 32'(ev.id));
    chk($sformatf("evt_edge_dut%0d", id), 32'(e), 32'(ev.edge_n));
    chk($sformatf("evt_val_dut%0d_e%0d", id, e), 32'(cur), 32'(ev.val));
  endtask

  initial begin
    forever begin
      @(posedge clk or negedge rst0_n or negedge rst1_n);
      #1;
      observe(0, e0, pk(bus0.dom_rst_n_o, bus0.ready_o, bus0.rst_cause_o, bus0.lock_timeout_o));
      observe(1, e1, pk(bus1.dom_rst_n_o, bus1.ready_o, bus1.rst_cause_o, bus1.lock_timeout_o));
    end
  end

  task automatic wait_edge(int id, int n);
    for (int i = 0; i < 5000 && cnt_of(id) < n; i++) @(negedge clk);
    if (cnt_of(id) < n) chk($sformatf("wait_timeout_dut%0d", id), 32'(cnt_of(id)), 32'(n));
  endtask

  // Drive a one-cycle request so that it is sampled at edge e.
  task automatic pulse(int id, logic sw, logic wdt, int e);
    wait_edge(id, e - 1);
    if (id == 0) begin bus0.sw_rst_req_i = sw; bus0.wdt_rst_req_i = wdt; end
    else         begin bus1.sw_rst_req_i = sw; bus1.wdt_rst_req_i = wdt; end
    @(negedge clk);
    bus0.sw_rst_req_i = 1'b0; bus0.wdt_rst_req_i = 1'b0;
    bus1.sw_rst_req_i = 1'b0; bus1.wdt_rst_req_i = 1'b0;
  endtask

  initial begin
    bus0.pll_lock_i = 1'b1; bus0.sw_rst_req_i = 1'b0; bus0.wdt_rst_req_i = 1'b0;
    bus1.pll_lock_i = 1'b0; bus1.sw_rst_req_i = 1'b0; bus1.wdt_rst_req_i = 1'b0;
    #1;
    rst0_n = 1'b0;
    rst1_n = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_dom0",   32'(bus0.dom_rst_n_o),    32'h0);
    chk("rst_ready0", 32'(bus0.ready_o),        32'h0);
    chk("rst_cause0", 32'(bus0.rst_cause_o),    32'h1);
    chk("rst_lt0",    32'(bus0.lock_timeout_o), 32'h0);
    chk("rst_dom1",   32'(bus1.dom_rst_n_o),    32'h0);
    chk("rst_cause1", 32'(bus1.rst_cause_o),    32'h1);

    // POR with lock held: releases at 17/25/33/41
    push_seq(0, 0, 17, 4, 2'b01, 1'b0);
    #2 rst0_n = 1'b1;
    wait_edge(0, 45);
    bus0.pll_lock_i = 1'b0;
    wait_edge(0, 48);
    chk("run_ignores_lock_loss", 32'(bus0.ready_o), 32'h1);
    bus0.pll_lock_i = 1'b1;

    // SW request in RUN at edge 50
    push(0, 50, pk(4'h0, 1'b0, 2'b10, 1'b0));
    push_seq(0, 50, 17, 4, 2'b10, 1'b0);
    pulse(0, 1'b1, 1'b0, 50);
    wait_edge(0, 95);

    // SW and WDT together at edge 100: WDT cause, one restart
    push(0, 100, pk(4'h0, 1'b0, 2'b11, 1'b0));
    push_seq(0, 100, 17, 4, 2'b11, 1'b0);
    pulse(0, 1'b1, 1'b1, 100);
    wait_edge(0, 145);

    // SW at 150, then rst_n dropped mid-RELEASE after two domains are out
    push(0, 150, pk(4'h0, 1'b0, 2'b10, 1'b0));
    push_seq(0, 150, 17, 2, 2'b10, 1'b0);
    pulse(0, 1'b1, 1'b0, 150);
    wait_edge(0, 178);
    push(0, 0, pk(4'h0, 1'b0, 2'b01, 1'b0));
    #2 rst0_n = 1'b0;
    #1;
    chk("async_dom",   32'(bus0.dom_rst_n_o),    32'h0);
    chk("async_ready", 32'(bus0.ready_o),        32'h0);
    chk("async_cause", 32'(bus0.rst_cause_o),    32'h1);
    chk("async_lt",    32'(bus0.lock_timeout_o), 32'h0);
    @(negedge clk);

    // Fresh POR, WDT at edge 30 after domains 0-1 are out
    push_seq(0, 0, 17, 2, 2'b01, 1'b0);
    push(0, 30, pk(4'h0, 1'b0, 2'b11, 1'b0));
    push_seq(0, 30, 17, 4, 2'b11, 1'b0);
    #2 rst0_n = 1'b1;
    pulse(0, 1'b0, 1'b1, 30);
    wait_edge(0, 75);

    // Lock never arrives, LOCK_TIMEOUT=64: forced release at 80
    push_seq(1, 0, 80, 4, 2'b01, 1'b1);
    push(1, 110, pk(4'h0, 1'b0, 2'b10, 1'b1));
    push_seq(1, 110, 80, 4, 2'b10, 1'b1);
    #2 rst1_n = 1'b1;
    wait_edge(1, 105);
    chk("timeout_lt_set", 32'(bus1.lock_timeout_o), 32'h1);
    pulse(1, 1'b1, 1'b0, 110);
    wait_edge(1, 218);
    chk("timeout_lt_sticky", 32'(bus1.lock_timeout_o), 32'h1);
    chk("timeout_ready",     32'(bus1.ready_o),        32'h1);
    chk("dut0_still_run",    32'(bus0.ready_o),        32'h1);

    chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
